// File: rtl/dspedal_i2s_pkg.sv
// Shared constants and helpers for the I2S transmit/receive blocks.
package dspedal_i2s_pkg;

    // LRCLK level for each channel (Philips I2S)
    localparam logic LRCLK_LEFT  = 1'b0;
    localparam logic LRCLK_RIGHT = 1'b1;

    // Default number of BCLK periods per channel slot
    localparam int unsigned SLOT_DEFAULT = 32;

    // Width of the frame-position counter covering 0 .. 2*slot-1
    function automatic int unsigned pos_width(input int unsigned slot);
        return $clog2(2 * slot);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider and frame-position counter, shared by the I2S tx and rx paths.
// fall_c marks the clk edge on which BCLK goes low; p_c is the frame position
// in effect from that edge onward (equal to the held position otherwise).
module i2s_bclk_gen
    import dspedal_i2s_pkg::*;
#(
    parameter int unsigned SLOT     = SLOT_DEFAULT,
    parameter int unsigned BCLK_DIV = 2,
    localparam int unsigned PW      = pos_width(SLOT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          bclk_o,
    output logic          fall_c,
    output logic [PW-1:0] p_c
);

    localparam int unsigned CW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned PMAX = 2 * SLOT - 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic [PW-1:0] p_q, p_d;

    // Divider wrap toggles BCLK; a high-to-low toggle advances the position
    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        p_d    = p_q;
        fall_c = 1'b0;
        if (cnt_q == CW'(BCLK_DIV - 1)) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
            fall_c = bclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (fall_c) begin
            p_d = (p_q == PW'(PMAX)) ? '0 : p_q + PW'(1);
        end
    end

    // Position starts at the last slot bit so the first fall opens a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
            p_q    <= PW'(PMAX);
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
            p_q    <= p_d;
        end
    end

    assign bclk_o = bclk_q;
    assign p_c    = p_d;

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream stereo sample sink driving a Philips I2S DAC link as bus master.
// One holding register absorbs a sample while the current frame is shifting.
module axis_i2s_tx
    import dspedal_i2s_pkg::*;
#(
    parameter int unsigned DW       = 24,
    parameter int unsigned SLOT     = SLOT_DEFAULT,
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic            i2s_bclk,
    output logic            i2s_lrclk,
    output logic            i2s_sdata,
    output logic            frame_start,
    output logic            underrun
);

    localparam int unsigned PW = pos_width(SLOT);
    localparam int unsigned SW = 2 * DW;
    localparam int unsigned IW = (SW > 1) ? $clog2(SW) : 1;

    logic          fall_c;
    logic [PW-1:0] p_c;

    logic [SW-1:0] hold_q, hold_d;
    logic          ready_q, ready_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          fstart_q, fstart_d;
    logic          urun_q, urun_d;
    logic          load;
    logic [31:0]   pos;

    i2s_bclk_gen #(
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .rst    (rst),
        .bclk_o (i2s_bclk),
        .fall_c (fall_c),
        .p_c    (p_c)
    );

    // Handshake, frame load from the holding register, and serial bit select
    always_comb begin
        hold_d   = hold_q;
        ready_d  = ready_q;
        shreg_d  = shreg_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        fstart_d = 1'b0;
        urun_d   = 1'b0;
        pos      = 32'(p_c);
        load     = fall_c && (p_c == '0);

        if (s_axis_tvalid && ready_q) begin
            hold_d  = s_axis_tdata;
            ready_d = 1'b0;
        end

        // A sample arriving on the load edge itself waits for the next frame
        if (load) begin
            fstart_d = 1'b1;
            if (!ready_q) begin
                shreg_d = hold_q;
                ready_d = 1'b1;
            end else begin
                shreg_d = '0;
                urun_d  = 1'b1;
            end
        end

        if (fall_c) begin
            lrclk_d = (pos >= SLOT - 1 && pos <= 2 * SLOT - 2) ? LRCLK_RIGHT : LRCLK_LEFT;
            sdata_d = 1'b0;
            if (pos < DW) begin
                sdata_d = shreg_d[IW'(SW - 1 - pos)];
            end else if (pos >= SLOT && pos < SLOT + DW) begin
                sdata_d = shreg_d[IW'(DW - 1 - (pos - SLOT))];
            end
        end
    end

    // State and output registers; reset drops any held sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q   <= '0;
            ready_q  <= 1'b1;
            shreg_q  <= '0;
            lrclk_q  <= LRCLK_LEFT;
            sdata_q  <= 1'b0;
            fstart_q <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            shreg_q  <= shreg_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            fstart_q <= fstart_d;
            urun_q   <= urun_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_sdata     = sdata_q;
    assign frame_start   = fstart_q;
    assign underrun      = urun_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Bench for axis_i2s_tx: timeline-based reference model plus directed and random traffic.
module tb_axis_i2s_tx;

    localparam int unsigned DW  = 24;
    localparam int unsigned SLOT = 32;
    localparam int unsigned BD  = 2;
    localparam int unsigned FR  = 4 * SLOT * BD;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2*DW-1:0] s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

    axis_i2s_tx #(.DW(DW), .SLOT(SLOT), .BCLK_DIV(BD)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: time since reset release ----------------
    int unsigned     mk = 0;
    int unsigned     m_pos = 2 * SLOT - 1;
    bit              m_hv = 0, m_bclk = 0, m_lr = 0, m_sd = 0, m_fs = 0, m_ur = 0;
    bit              m_acc = 0, m_fell = 0;
    int unsigned     m_acc_k = 0;
    logic [2*DW-1:0] m_hold = '0, m_frame = '0;
    logic [2*DW-1:0] acc_q[$];

    function automatic bit exp_sd(input logic [2*DW-1:0] f, input int unsigned p);
        logic [DW-1:0] l, r;
        l = f[2*DW-1:DW];
        r = f[DW-1:0];
        if (p < DW) return l[DW-1-p];
        if (p >= SLOT && p < SLOT + DW) return r[DW-1-(p-SLOT)];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit xfer;
        if (!rst) begin
            mk = 0; m_pos = 2 * SLOT - 1; m_hv = 0; m_hold = '0; m_frame = '0;
            m_bclk = 0; m_lr = 0; m_sd = 0; m_fs = 0; m_ur = 0; m_acc = 0; m_fell = 0;
            acc_q.delete();
        end else begin
            xfer   = s_axis_tvalid && !m_hv;
            mk++;
            m_bclk = ((mk / BD) % 2) == 1;
            m_fs = 0; m_ur = 0; m_acc = xfer; m_fell = 0;
            if (mk % (2 * BD) == 0) begin
                m_fell = 1;
                m_pos  = (2 * SLOT - 1 + mk / (2 * BD)) % (2 * SLOT);
                if (m_pos == 0) begin
                    m_fs = 1;
                    if (m_hv) begin m_frame = m_hold; m_hv = 0; end
                    else begin m_frame = '0; m_ur = 1; end
                end
                m_lr = (m_pos >= SLOT - 1) && (m_pos <= 2 * SLOT - 2);
                m_sd = exp_sd(m_frame, m_pos);
            end
            if (xfer) begin
                m_hold = s_axis_tdata; m_hv = 1; m_acc_k = mk;
                acc_q.push_back(s_axis_tdata);
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, s_axis_tready},
            {m_bclk, m_lr, m_sd, m_fs, m_ur, !m_hv});
    end

    // ---------------- frame reassembly from the serial line ----------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned fs_cnt = 0, ur_cnt = 0, fs_cyc = 0, fs_prev = 0, bcnt = 0;
    int unsigned ur_cyc[3] = '{0, 0, 0};
    logic [63:0] shf = '0, last_frame = '0;
    bit          prev_bclk = 0, sd_or = 0;

    function automatic logic [63:0] expand(input logic [2*DW-1:0] s);
        return {s[2*DW-1:DW], (SLOT-DW)'(0), s[DW-1:0], (SLOT-DW)'(0)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            bcnt = 0; prev_bclk = 0;
        end else begin
            if (frame_start) begin
                if (bcnt == 2 * SLOT) begin
                    last_frame = shf;
                    if (shf != 0) begin
                        if (acc_q.size() == 0) chk("frame_data", shf, 64'h0);
                        else chk("frame_data", shf, expand(acc_q.pop_front()));
                    end
                end
                bcnt = 0; fs_cnt++; fs_prev = fs_cyc; fs_cyc = cyc;
            end
            if (underrun) begin
                ur_cnt++; ur_cyc[0] = ur_cyc[1]; ur_cyc[1] = ur_cyc[2]; ur_cyc[2] = cyc;
            end
            if (i2s_bclk && !prev_bclk) begin
                shf = {shf[62:0], i2s_sdata}; bcnt++;
            end
            prev_bclk = i2s_bclk;
            sd_or = sd_or | i2s_sdata;
        end
    end

    // ---------------- stimulus helpers (entered and left at a negedge) ----------------
    task automatic send(input logic [2*DW-1:0] d);
        int n = 0;
        s_axis_tdata = d; s_axis_tvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!m_acc && n < 1000);
        chk("send_accept", m_acc, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_before_load();
        int n = 0;
        int unsigned nk;
        nk = mk + 1;
        while (!((nk % (2 * BD) == 0) && ((2 * SLOT - 1 + nk / (2 * BD)) % (2 * SLOT) == 0)) && n < 600) begin
            @(negedge clk); n++; nk = mk + 1;
        end
        chk("load_reached", n < 600, 1);
    endtask

    task automatic wait_pos(input int unsigned p);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(m_fell && m_pos == p) && n < 600);
        chk("pos_reached", m_pos, p);
    endtask

    int unsigned kA, kB, kC, ur_base;
    logic [2*DW-1:0] rd;

    initial begin
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, s_axis_tready}, 6'b000001);

        // Release and offer one sample before the first frame
        rst = 1'b1;
        s_axis_tdata = 48'h800001_7FFFFF; s_axis_tvalid = 1'b1;
        @(negedge clk); chk("edge1", {i2s_bclk, s_axis_tready}, 2'b00);
        s_axis_tvalid = 1'b0;
        @(negedge clk); chk("first_rise", i2s_bclk, 1);
        @(negedge clk); chk("bclk_high", i2s_bclk, 1);
        @(negedge clk);
        chk("first_fall", {i2s_bclk, frame_start, underrun, i2s_sdata, s_axis_tready, i2s_lrclk}, 6'b010110);
        wait_pos(30); chk("lrclk_p30", i2s_lrclk, 0);
        wait_pos(31); chk("lrclk_p31", i2s_lrclk, 1);
        wait_pos(62); chk("lrclk_p62", i2s_lrclk, 1);
        wait_pos(63); chk("lrclk_p63", i2s_lrclk, 0);
        chk("order_no_underrun", ur_cnt, 0);
        chk("order_one_frame", fs_cnt, 1);
        wait_before_load(); @(negedge clk); #1;
        chk("frame_period", fs_cyc - fs_prev, FR);
        chk("order_bits", last_frame, 64'h80000100_7FFFFF00);
        chk("idle_load_underrun", {frame_start, underrun}, 2'b11);

        // Backpressure: A, B, C back-to-back
        ur_base = ur_cnt;
        send(48'hA1A2A3_A4A5A6); kA = m_acc_k;
        chk("tready_drops", s_axis_tready, 0);
        send(48'hB1B2B3_B4B5B6); kB = m_acc_k;
        send(48'hC1C2C3_C4C5C6); kC = m_acc_k;
        chk("b_wait", kB - kA, FR);
        chk("b_after_load", (kB - 1 - 2 * BD) % FR, 0);
        chk("c_wait", kC - kB, FR);
        wait_before_load(); @(negedge clk); #1;
        chk("abc_no_underrun", ur_cnt - ur_base, 0);

        // Three idle frames
        ur_base = ur_cnt;
        wait_before_load(); @(negedge clk); #1; sd_or = 0;
        wait_before_load(); @(negedge clk);
        wait_before_load(); @(negedge clk);
        repeat (100) @(negedge clk);
        #1;
        chk("underrun_count", ur_cnt - ur_base, 3);
        chk("underrun_gap1", ur_cyc[1] - ur_cyc[0], FR);
        chk("underrun_gap2", ur_cyc[2] - ur_cyc[1], FR);
        chk("idle_sdata_zero", sd_or, 0);
        send(48'h123456_654321);
        wait_before_load(); @(negedge clk);
        chk("mid_frame_sample_load", {frame_start, underrun}, 2'b10);

        // Sample offered exactly on the load edge with the holding register empty
        wait_before_load();
        s_axis_tdata = 48'h5A5A5A_A5A5A5; s_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("race_load", {frame_start, underrun, s_axis_tready}, 3'b110);
        s_axis_tvalid = 1'b0;
        wait_before_load(); @(negedge clk);
        chk("race_next_frame", {frame_start, underrun}, 2'b10);

        // Reset mid-frame while a sample is held
        send(48'h0F0F0F_F0F0F0);
        wait_pos(40);
        #2 rst = 1'b0;
        #1 chk("async_reset", {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, s_axis_tready}, 6'b000001);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_underrun", {i2s_bclk, frame_start, underrun}, 3'b011);

        // Random traffic with random gaps
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 500)) @(negedge clk);
            rd = {16'($urandom), 32'($urandom)};
            if (rd == '0) rd = 48'h1;
            send(rd);
        end
        repeat (600) @(negedge clk);
        #1;
        chk("drain", acc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_i2s_tx.md
Name: axis_i2s_tx

Overview:
- AXI-Stream sink that serialises stereo audio samples onto an I2S output toward the codec DAC.
- Sits at the tail of the DSP chain, after the last skid stage. It is the consuming end of the sample stream.
- Generates BCLK and LRCLK as bus master from the system clock, with a one-sample holding register for backpressure.
- Flags underrun when no sample is available at a frame boundary.

Parameters:
- DW, 24, sample width per channel; must satisfy 1 <= DW <= SLOT.
- SLOT, 32, BCLK periods per channel slot.
- BCLK_DIV, 2, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  2*DW  stereo sample; left channel in [2*DW-1:DW], right channel in [DW-1:0], two's complement.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  holding register empty.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- frame_start  out  1  one-clk pulse when a new frame is loaded.
- underrun  out  1  one-clk pulse when a frame is loaded with no sample available.

Behaviour:
- Reset (async assert, sync release): i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_start=0, underrun=0.
  - Holding register is emptied, so s_axis_tready=1.
  - Divider count = 0; frame position p = 2*SLOT-1; shift register = 0.
- Divider:
  - Counts 0..BCLK_DIV-1 and toggles i2s_bclk on wrap.
  - A 1->0 toggle is a "fall event", at which p advances modulo 2*SLOT.
  - BCLK period = 2*BCLK_DIV clk; frame = 2*SLOT BCLK = 4*SLOT*BCLK_DIV clk.
  - First fall event occurs 2*BCLK_DIV clk after reset release.
- All serial outputs are registered and update only on fall events; receivers sample on BCLK rise.
- Output values at position p:
  - i2s_lrclk = 1 iff SLOT-1 <= p <= 2*SLOT-2, i.e. LRCLK leads its slot's MSB by one BCLK (Philips I2S).
  - i2s_sdata = left[DW-1-p] for p < DW.
  - i2s_sdata = right[DW-1-(p-SLOT)] for SLOT <= p < SLOT+DW.
  - i2s_sdata = 0 elsewhere.
- Handshake:
  - s_axis_tready = !hold_valid, driven from a register with no combinational path from tvalid.
  - A transfer occurs when tvalid && tready; tdata is captured and hold_valid is set.
- Frame load, on the fall event where p becomes 0:
  - If hold_valid (registered value) is set: shift register <= held sample, hold_valid <= 0, frame_start pulses.
  - Otherwise: shift register <= 0, and both frame_start and underrun pulse.
  - If a transfer happens on the load cycle while the holding register is empty, that sample is captured into the holding register for the next frame. It is not used for the current frame, and underrun still pulses.
- A sample is never dropped or duplicated.
- Throughput is at most 1 sample per frame; the upstream is stalled otherwise.
- Reset mid-frame: outputs return to reset values immediately and the held sample is discarded. The next frame starts cleanly at p=0 after reset release.

Decomposition:
- Package dspedal_i2s_pkg holds:
  - LRCLK polarity constants (LEFT=0, RIGHT=1);
  - the default SLOT localparam;
  - a function returning the frame position width, $clog2(2*SLOT).
- Sub-module i2s_bclk_gen: the divider plus frame-position counter. It outputs i2s_bclk, a fall-event strobe and p; it is reusable by a future i2s_rx.
- The top level holds the holding register, shift register and output logic.

Test Plan:
- Reset check: hold rst=0, release → all outputs 0 and tready=1. First BCLK rise at 2 clk after release and first fall at 4 clk (BCLK_DIV=2); the frame period is 256 clk.
- Data ordering: send one sample L=0x800001, R=0x7FFFFF before the first frame.
  - On BCLK rises, the left bits are 1,0×22,1 then 8 zeros.
  - The right bits are 0,1×23 then 8 zeros.
  - LRCLK rises at p=31 and falls at p=63; frame_start pulses once and underrun never pulses.
- Backpressure: offer three samples A, B, C back-to-back.
  - A is accepted and tready drops.
  - B is accepted only after A's frame load, and C only after B's load.
  - The serial output shows A, B, C on consecutive frames with no gaps or repeats.
- Underrun: no tvalid for 3 frames → sdata constantly 0 and underrun pulses exactly 3 times, 256 clk apart. A sample then sent mid-frame is transmitted on the next frame with no underrun.
- Load-cycle race: assert tvalid on exactly the clk of the p→0 load while the holding register is empty → underrun pulses, and the sample is emitted in the following frame.
- Mid-frame reset: assert rst at p=40 while holding a sample → outputs go to 0 asynchronously and tready=1 during reset. After release, the first frame is an underrun (zeros) unless new data is sent.
